// File: rtl/fir_tap_sequencer.sv
// Sample delay line plus coefficient file feeding a 64-tap MAC: one accepted sample yields a
// contiguous burst of TAPS (coef, sample) pairs. Define SYM_COEF_EN for symmetric coefficients.
module fir_tap_sequencer #(
    parameter int TAPS = 64,
    parameter int DW   = 16,
    parameter int AW   = 6
) (
    input  logic          clk2,
    input  logic          rst,
    input  logic          sample_valid,
    input  logic [DW-1:0] sample_in,
    output logic          sample_ready,
    input  logic          coef_we,
    input  logic [AW-1:0] coef_addr,
    input  logic [DW-1:0] coef_wdata,
    output logic          coef_err,
    output logic          enable,
    output logic [DW-1:0] cout,
    output logic [DW-1:0] x_in,
    output logic          frame_start,
    output logic          busy
);

`ifdef SYM_COEF_EN
    localparam int CN  = TAPS / 2;
    localparam int CAW = AW - 1;
`else
    localparam int CN  = TAPS;
    localparam int CAW = AW;
`endif

    typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wp_q, wp_d, np_q, np_d, k_q, k_d;
    logic [DW-1:0] line_q [TAPS];
    logic [DW-1:0] line_d [TAPS];
    logic [DW-1:0] coef_q [CN];
    logic [DW-1:0] coef_d [CN];
    logic          ready_q, ready_d, enable_q, enable_d, frame_q, frame_d;
    logic          busy_q, busy_d, err_q, err_d;
    logic [DW-1:0] cout_q, cout_d, x_q, x_d;
    logic          accept_s, coef_ok_s;
    logic [CAW-1:0] coef_wsel_s, coef_rsel_s;
    logic [AW-1:0] x_idx_s;

    assign accept_s = sample_valid && ready_q;
    assign x_idx_s  = np_q - k_q;

`ifdef SYM_COEF_EN
    // Upper-half taps mirror the lower half: index TAPS-1-k is the bitwise complement of k.
    assign coef_ok_s   = coef_we && (state_q == IDLE) && !accept_s && !coef_addr[AW-1];
    assign coef_wsel_s = coef_addr[CAW-1:0];
    assign coef_rsel_s = k_q[AW-1] ? ~k_q[CAW-1:0] : k_q[CAW-1:0];
`else
    assign coef_ok_s   = coef_we && (state_q == IDLE) && !accept_s;
    assign coef_wsel_s = coef_addr;
    assign coef_rsel_s = k_q;
`endif

    // State register
    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one burst of TAPS pairs per accepted sample
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) state_d = STREAM;
                else          state_d = IDLE;
            end
            STREAM: begin
                if (k_q == AW'(TAPS - 1)) state_d = IDLE;
                else                      state_d = STREAM;
            end
            default: state_d = IDLE;
        endcase
    end

    // Delay line, pointers, tap counter and coefficient file updates
    always_comb begin
        wp_d   = wp_q;
        np_d   = np_q;
        k_d    = k_q;
        line_d = line_q;
        coef_d = coef_q;
        if (accept_s) begin
            line_d[wp_q] = sample_in;
            np_d         = wp_q;
            wp_d         = wp_q + AW'(1'b1);
            k_d          = '0;
        end else if (state_q == STREAM) begin
            k_d = k_q + AW'(1'b1);
        end else begin
            k_d = k_q;
        end
        if (coef_ok_s) begin
            coef_d[coef_wsel_s] = coef_wdata;
        end else begin
            coef_d = coef_q;
        end
    end

    // Output logic; busy spans from accept until the last pair has been retired
    always_comb begin
        ready_d = (state_d == IDLE);
        busy_d  = (state_d == STREAM) || (state_q == STREAM);
        err_d   = coef_we && !coef_ok_s;
        if (state_q == STREAM) begin
            enable_d = 1'b1;
            frame_d  = (k_q == '0);
            cout_d   = coef_q[coef_rsel_s];
            x_d      = line_q[x_idx_s];
        end else begin
            enable_d = 1'b0;
            frame_d  = 1'b0;
            cout_d   = '0;
            x_d      = '0;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            wp_q     <= '0;
            np_q     <= '0;
            k_q      <= '0;
            for (int i = 0; i < TAPS; i++) line_q[i] <= '0;
            for (int i = 0; i < CN; i++)   coef_q[i] <= '0;
            ready_q  <= 1'b0;
            enable_q <= 1'b0;
            frame_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            cout_q   <= '0;
            x_q      <= '0;
        end else begin
            wp_q     <= wp_d;
            np_q     <= np_d;
            k_q      <= k_d;
            line_q   <= line_d;
            coef_q   <= coef_d;
            ready_q  <= ready_d;
            enable_q <= enable_d;
            frame_q  <= frame_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            cout_q   <= cout_d;
            x_q      <= x_d;
        end
    end

    assign sample_ready = ready_q;
    assign enable       = enable_q;
    assign frame_start  = frame_q;
    assign busy         = busy_q;
    assign coef_err     = err_q;
    assign cout         = cout_q;
    assign x_in         = x_q;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Self-checking bench for fir_tap_sequencer: directed and random samples against a
// sample-history / coefficient-array reference model.
module tb_fir_tap_sequencer;

    logic        clk2;
    logic        rst;
    logic        sample_valid;
    logic [15:0] sample_in;
    logic        sample_ready;
    logic        coef_we;
    logic [5:0]  coef_addr;
    logic [15:0] coef_wdata;
    logic        coef_err;
    logic        enable;
    logic [15:0] cout;
    logic [15:0] x_in;
    logic        frame_start;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] hist [$];
    logic [15:0] coef_m [64];

    fir_tap_sequencer #(.TAPS(64), .DW(16), .AW(6)) dut (
        .clk2         (clk2),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .sample_ready (sample_ready),
        .coef_we      (coef_we),
        .coef_addr    (coef_addr),
        .coef_wdata   (coef_wdata),
        .coef_err     (coef_err),
        .enable       (enable),
        .cout         (cout),
        .x_in         (x_in),
        .frame_start  (frame_start),
        .busy         (busy)
    );

    initial clk2 = 1'b0;
    always #5 clk2 = ~clk2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference coefficient write; returns 1 when the write must be rejected.
    function automatic logic model_write(input logic [5:0] k, input logic [15:0] v);
`ifdef SYM_COEF_EN
        if (k < 6'd32) begin
            coef_m[k]          = v;
            coef_m[6'd63 - k]  = v;
            return 1'b0;
        end else begin
            return 1'b1;
        end
`else
        coef_m[k] = v;
        return 1'b0;
`endif
    endfunction

    task automatic model_clear();
        hist.delete();
        for (int i = 0; i < 64; i++) coef_m[i] = 16'h0000;
    endtask

    // Idle-time coefficient write; called at a falling edge.
    task automatic write_coef(input logic [5:0] k, input logic [15:0] v);
        logic exp_err;
        coef_we    = 1'b1;
        coef_addr  = k;
        coef_wdata = v;
        @(negedge clk2);
        coef_we = 1'b0;
        exp_err = model_write(k, v);
        chk("coef_err_idle", 64'(coef_err), 64'(exp_err));
    endtask

    // One accept plus full burst check. wmode: 0 none, 1 write at accept, 2 write coef[5] mid-burst.
    task automatic run_sample(input logic [15:0] v, input int wmode, input int abort_tap);
        logic [15:0] exp_x;
        int n;
        int idx;
        chk("ready_before_accept", 64'(sample_ready), 64'(1'b1));
        sample_valid = 1'b1;
        sample_in    = v;
        if (wmode == 1) begin
            coef_we    = 1'b1;
            coef_addr  = 6'($urandom);
            coef_wdata = 16'($urandom);
        end
        @(negedge clk2);
        sample_valid = 1'b0;
        sample_in    = 16'($urandom);
        coef_we      = 1'b0;
        hist.push_back(v);
        chk("after_accept", 64'({busy, sample_ready, enable, coef_err}),
            64'({1'b1, 1'b0, 1'b0, (wmode == 1)}));
        n = hist.size() - 1;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk2);
            idx   = n - k;
            exp_x = (idx >= 0) ? hist[idx] : 16'h0000;
            chk($sformatf("tap%0d", k),
                64'({enable, frame_start, coef_err, busy, cout, x_in}),
                64'({1'b1, (k == 0), (wmode == 2 && k == 21), 1'b1, coef_m[k], exp_x}));
            if (wmode == 2 && k == 20) begin
                coef_we    = 1'b1;
                coef_addr  = 6'd5;
                coef_wdata = 16'hFFFF;
            end else begin
                coef_we = 1'b0;
            end
            if (k == abort_tap) begin
                #2 rst = 1'b1;
                #1;
                chk("rst_mid_burst", 64'({enable, busy, sample_ready, frame_start, cout, x_in}),
                    64'(0));
                model_clear();
                @(negedge clk2);
                rst = 1'b0;
                @(negedge clk2);
                chk("rst_release_idle",
                    64'({sample_ready, enable, busy, frame_start, coef_err, cout, x_in}),
                    64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000}));
                return;
            end
        end
        @(negedge clk2);
        chk("burst_end", 64'({enable, frame_start, busy, sample_ready, coef_err}),
            64'({1'b0, 1'b0, 1'b0, 1'b1, 1'b0}));
    endtask

    initial begin
        int last;
        int acc;
        int en_cnt;
        logic took;

        rst          = 1'b1;
        sample_valid = 1'b0;
        sample_in    = 16'h0000;
        coef_we      = 1'b0;
        coef_addr    = 6'd0;
        coef_wdata   = 16'h0000;
        model_clear();

        // Reset and idle state
        repeat (3) @(negedge clk2);
        chk("in_reset", 64'({sample_ready, enable, busy, frame_start, coef_err}), 64'(0));
        rst = 1'b0;
        @(negedge clk2);
        chk("idle_after_reset",
            64'({sample_ready, enable, busy, frame_start, coef_err, cout, x_in}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000}));

        // Impulse response
        for (int k = 0; k < 64; k++) write_coef(6'(k), 16'(k + 1));
        run_sample(16'h0100, 0, -1);
        run_sample(16'h0000, 0, -1);

        // Ordering and wrap: values 1..70
        for (int s = 1; s <= 70; s++) run_sample(16'(s), 0, -1);

        // Back-to-back handshake with sample_valid held high
        last   = 0;
        acc    = 0;
        en_cnt = 0;
        sample_valid = 1'b1;
        sample_in    = 16'($urandom);
        for (int cyc = 0; cyc < 400 && acc < 4; cyc++) begin
            took = 1'b0;
            if (enable) en_cnt++;
            if (acc > 0 && (cyc - last) >= 1 && (cyc - last) <= 64)
                chk("ready_low_in_burst", 64'(sample_ready), 64'(1'b0));
            if (sample_ready) begin
                if (acc > 0) begin
                    chk("accept_gap", 64'(cyc - last), 64'(65));
                    chk("enable_count", 64'(en_cnt), 64'(64));
                end
                en_cnt = 0;
                last   = cyc;
                acc++;
                took   = 1'b1;
                hist.push_back(sample_in);
            end
            @(posedge clk2);
            #1;
            if (took) begin
                sample_in = 16'($urandom);
                if (acc == 4) sample_valid = 1'b0;
            end
            @(negedge clk2);
        end
        chk("accept_total", 64'(acc), 64'(4));
        repeat (65) @(negedge clk2);
        chk("handshake_drain", 64'({enable, busy, sample_ready}), 64'({1'b0, 1'b0, 1'b1}));

        // Coefficient write in STREAM and at an accept edge are rejected
        run_sample(16'($urandom), 2, -1);
        run_sample(16'($urandom), 1, -1);
        run_sample(16'($urandom), 0, -1);

        // Randomized coefficients and samples
        for (int it = 0; it < 10; it++) begin
            repeat ($urandom_range(0, 3)) write_coef(6'($urandom), 16'($urandom));
            run_sample(16'($urandom), int'($urandom_range(0, 2)), -1);
        end

        // Reset at tap 30, then zero-history burst
        run_sample(16'($urandom), 0, 30);
        run_sample(16'($urandom), 0, -1);
        write_coef(6'd3, 16'h0042);
        write_coef(6'd40, 16'h1234);
        run_sample(16'($urandom), 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
